// File: rtl/famicom_bus_pkg.sv
// Shared types and constants for the Famicom CPU bus initiator.
// Used by the phase timer, the bus master top and its benches.
package famicom_bus_pkg;

    typedef enum logic [0:0] {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // Filler reads target internal RAM, so the cartridge never sees ROMSEL.
    localparam logic [15:0] CPU_RAM_DUMMY = 16'h0000;

    localparam int IRQ_SYNC_STAGES = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [7:0]  wdata;
    } bus_req_t;

endpackage

// File: rtl/famicom_cpu_bus_master_if.sv
// Request/response handshake plus the cartridge-side CPU bus pins.
// The master modport is the initiator's view; slave is the far side.
interface famicom_cpu_bus_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_write;
    logic [7:0]  req_wdata;

    logic        rsp_valid;
    logic        rsp_write;
    logic [7:0]  rsp_rdata;

    logic        m2;
    logic        romsel;
    logic        cpu_rw;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic [7:0]  cpu_data_in;

    logic        irq_n;
    logic        irq_active;
    logic [15:0] m2_cycles;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, cpu_data_in, irq_n,
        output req_ready, rsp_valid, rsp_write, rsp_rdata,
               m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe,
               irq_active, m2_cycles
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, cpu_data_in, irq_n,
        input  req_ready, rsp_valid, rsp_write, rsp_rdata,
               m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe,
               irq_active, m2_cycles
    );

endinterface

// File: rtl/m2_phase_timer.sv
// Free-running M2 low/high phase sequencer with a shared down-counter.
// o_rise marks the last LOW clk, o_boundary the last HIGH clk of a bus cycle.
module m2_phase_timer
    import famicom_bus_pkg::*;
#(
    parameter int LOW_CLKS  = 3,
    parameter int HIGH_CLKS = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_rise,
    output logic o_boundary
);

    localparam int CNT_MAX = (LOW_CLKS > HIGH_CLKS) ? LOW_CLKS : HIGH_CLKS;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CLKS - 1);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CLKS - 1);

    localparam logic [0:0] ST_LOW  = PH_LOW;
    localparam logic [0:0] ST_HIGH = PH_HIGH;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt - CNT_W'(1);
        if (w_cnt_zero) begin
            if (r_state == ST_LOW) begin
                w_state_next = ST_HIGH;
                w_cnt_next   = HIGH_LOAD;
            end else begin
                w_state_next = ST_LOW;
                w_cnt_next   = LOW_LOAD;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_LOW;
            r_cnt   <= LOW_LOAD;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_rise     = (r_state == ST_LOW)  && w_cnt_zero;
    assign o_boundary = (r_state == ST_HIGH) && w_cnt_zero;

endmodule

// File: rtl/famicom_cpu_bus_master.sv
// 6502-style cartridge bus initiator: runs M2 continuously, turns accepted
// requests into bus cycles, returns one response per real request.
module famicom_cpu_bus_master
    import famicom_bus_pkg::*;
#(
    parameter int          LOW_CLKS   = 3,
    parameter int          HIGH_CLKS  = 3,
    parameter logic [15:0] DUMMY_ADDR = CPU_RAM_DUMMY
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    famicom_cpu_bus_master_if.master  bus
);

    logic w_rise;
    logic w_boundary;

    m2_phase_timer #(
        .LOW_CLKS  (LOW_CLKS),
        .HIGH_CLKS (HIGH_CLKS)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .o_rise     (w_rise),
        .o_boundary (w_boundary)
    );

    bus_req_t w_next_req;

    // Current cycle attributes, held for the full LOW+HIGH span.
    logic [15:0] r_addr;
    logic        r_rw;
    logic [7:0]  r_wdata;
    logic        r_real;

    logic        r_m2;
    logic        r_romsel;
    logic        r_data_oe;
    logic [7:0]  r_data_out;
    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic [7:0]  r_rsp_rdata;
    logic        r_irq_active;
    logic [15:0] r_m2_cycles;
    logic [IRQ_SYNC_STAGES-1:0] r_irq_sync;

    always_comb begin
        w_next_req.addr  = DUMMY_ADDR;
        w_next_req.write = 1'b0;
        w_next_req.wdata = 8'h00;
        if (bus.req_valid) begin
            w_next_req.addr  = bus.req_addr;
            w_next_req.write = bus.req_write;
            w_next_req.wdata = bus.req_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq_sync <= '0;
        end else begin
            r_irq_sync <= {r_irq_sync[IRQ_SYNC_STAGES-2:0], ~bus.irq_n};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr       <= DUMMY_ADDR;
            r_rw         <= 1'b1;
            r_wdata      <= 8'h00;
            r_real       <= 1'b0;
            r_m2         <= 1'b0;
            r_romsel     <= 1'b1;
            r_data_oe    <= 1'b0;
            r_data_out   <= 8'h00;
            r_rsp_valid  <= 1'b0;
            r_rsp_write  <= 1'b0;
            r_rsp_rdata  <= 8'h00;
            r_irq_active <= 1'b0;
            r_m2_cycles  <= 16'h0000;
        end else begin
            r_rsp_valid <= 1'b0;

            if (w_rise) begin
                r_m2       <= 1'b1;
                r_romsel   <= ~r_addr[15];
                r_data_oe  <= ~r_rw;
                r_data_out <= r_rw ? 8'h00 : r_wdata;
            end

            // End of bus cycle: retire it and launch the next one.
            if (w_boundary) begin
                r_m2         <= 1'b0;
                r_romsel     <= 1'b1;
                r_data_oe    <= 1'b0;
                r_data_out   <= 8'h00;
                r_m2_cycles  <= r_m2_cycles + 16'd1;
                r_rsp_valid  <= r_real;
                r_rsp_write  <= ~r_rw;
                r_rsp_rdata  <= r_rw ? bus.cpu_data_in : 8'h00;
                r_irq_active <= r_irq_sync[IRQ_SYNC_STAGES-1];
                r_addr       <= w_next_req.addr;
                r_rw         <= ~w_next_req.write;
                r_wdata      <= w_next_req.wdata;
                r_real       <= bus.req_valid;
            end
        end
    end

    assign bus.req_ready    = w_boundary & ~i_rst;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_write    = r_rsp_write;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.m2           = r_m2;
    assign bus.romsel       = r_romsel;
    assign bus.cpu_rw       = r_rw;
    assign bus.cpu_addr     = r_addr[14:0];
    assign bus.cpu_data_out = r_data_out;
    assign bus.cpu_data_oe  = r_data_oe;
    assign bus.irq_active   = r_irq_active;
    assign bus.m2_cycles    = r_m2_cycles;

endmodule

// File: tb/tb_famicom_cpu_bus_master.sv
// Directed bench for famicom_cpu_bus_master with a response scoreboard
// and a simple cartridge model answering reads from the address.
`timescale 1ns/1ps
module tb_famicom_cpu_bus_master;

    typedef struct packed {
        logic        write;
        logic [7:0]  rdata;
        logic [31:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    famicom_cpu_bus_master_if bus();

    famicom_cpu_bus_master #(
        .LOW_CLKS   (3),
        .HIGH_CLKS  (3),
        .DUMMY_ADDR (16'h0000)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h87;
    endfunction

    assign bus.cpu_data_in = rom(bus.cpu_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1) begin
            chk("rsp_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                $display("rsp: write=%0d rdata=%02h cyc=%0d", bus.rsp_write, bus.rsp_rdata, cyc);
                chk("rsp_write", bus.rsp_write, mon_e.write);
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_latency", cyc - mon_e.acc, 6);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic w, input logic [7:0] d, output int acc);
        int   n = 0;
        exp_t e;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        while (bus.req_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_seen", n < 40, 1);
        acc     = cyc + 1;
        e.write = w;
        e.rdata = w ? 8'h00 : rom(a[14:0]);
        e.acc   = acc;
        sb.push_back(e);
        $display("req: write=%0d addr=%04h wdata=%02h acc_cyc=%0d", w, a, d, acc);
        @(negedge clk);
    endtask

    // Samples the six clks of the cycle just launched.
    task automatic observe(input string tag, input logic [15:0] a, input logic w, input logic [7:0] d);
        int errs = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.cpu_addr !== a[14:0]) errs++;
            if (bus.cpu_rw !== ~w) errs++;
            if (bus.m2 !== ((i >= 3) ? 1'b1 : 1'b0)) errs++;
            if (bus.romsel !== ~(bus.m2 & a[15])) errs++;
            if (bus.cpu_data_oe !== (bus.m2 & w)) errs++;
            if (bus.cpu_data_out !== ((bus.m2 & w) ? d : 8'h00)) errs++;
            @(negedge clk);
        end
        chk({tag, "_pins"}, errs, 0);
    endtask

    initial begin
        int a0, a1, a2, a3, acc;
        int m2_errs, romsel_lows, rw_lows;
        logic [15:0] c0, c3;

        bus.req_valid = 1'b1;
        bus.req_addr  = 16'h8000;
        bus.req_write = 1'b0;
        bus.req_wdata = 8'h00;
        bus.irq_n     = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_m2", bus.m2, 0);
        chk("rst_romsel", bus.romsel, 1);
        chk("rst_cpu_rw", bus.cpu_rw, 1);
        chk("rst_cpu_addr", bus.cpu_addr, 15'h0000);
        chk("rst_data_oe", bus.cpu_data_oe, 0);
        chk("rst_data_out", bus.cpu_data_out, 8'h00);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
        chk("rst_rsp_write", bus.rsp_write, 0);
        chk("rst_irq_active", bus.irq_active, 0);
        chk("rst_m2_cycles", bus.m2_cycles, 16'h0000);

        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Idle: 60 clks of dummy reads.
        m2_errs = 0; romsel_lows = 0; rw_lows = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.m2 !== (((n % 6) >= 3) ? 1'b1 : 1'b0)) m2_errs++;
            if (bus.romsel !== 1'b1) romsel_lows++;
            if (bus.cpu_rw !== 1'b1) rw_lows++;
        end
        chk("idle_m2_pattern", m2_errs, 0);
        chk("idle_romsel_low", romsel_lows, 0);
        chk("idle_rw_low", rw_lows, 0);
        chk("idle_m2_cycles", bus.m2_cycles, 16'd10);

        send(16'h8123, 1'b0, 8'h00, acc);
        bus.req_valid = 1'b0;
        observe("rd8123", 16'h8123, 1'b0, 8'h00);

        send(16'h6000, 1'b1, 8'h3C, acc);
        bus.req_valid = 1'b0;
        observe("wr6000", 16'h6000, 1'b1, 8'h3C);

        send(16'h8000, 1'b0, 8'h00, a0);
        c0 = bus.m2_cycles;
        send(16'hC001, 1'b0, 8'h00, a1);
        send(16'hFFFC, 1'b0, 8'h00, a2);
        send(16'h9ABC, 1'b0, 8'h00, a3);
        c3 = bus.m2_cycles;
        bus.req_valid = 1'b0;
        chk("b2b_gap1", a1 - a0, 6);
        chk("b2b_gap2", a2 - a1, 6);
        chk("b2b_gap3", a3 - a2, 6);
        chk("b2b_no_dummy", c3 - c0, 16'd3);
        repeat (8) @(negedge clk);

        // Abort a write in the second clk of its HIGH phase.
        send(16'h8005, 1'b1, 8'h77, acc);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_m2", bus.m2, 1);
        chk("pre_abort_oe", bus.cpu_data_oe, 1);
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_m2", bus.m2, 0);
        chk("abort_oe", bus.cpu_data_oe, 0);
        chk("abort_cpu_rw", bus.cpu_rw, 1);
        chk("abort_m2_cycles", bus.m2_cycles, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        observe("post_abort_dummy", 16'h0000, 1'b0, 8'h00);

        // IRQ: assert mid-LOW, release one cycle later.
        @(negedge clk);
        bus.irq_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("irq_before_boundary", bus.irq_active, 0);
        @(negedge clk);
        chk("irq_set", bus.irq_active, 1);
        @(negedge clk);
        bus.irq_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("irq_held", bus.irq_active, 1);
        @(negedge clk);
        chk("irq_clear", bus.irq_active, 0);

        repeat (10) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
